// File: rtl/lfsr_gen.sv
// lfsr_gen: configurable XNOR-feedback LFSR sequence generator.
//
// Ports
//   clk_i        clock, rising edge
//   nreset_i     asynchronous active-low reset
//   cfg_we_i     config write strobe (one cycle per write)
//   cfg_addr_i   register select: 0 seed, 1 stop, 2 taps, 3 mode
//   cfg_data_i   config write data
//   cfg_rdata_o  combinational readback of the selected register
//   cfg_ack_o    pulse one cycle after an accepted write
//   cfg_err_o    pulse one cycle after a rejected write (writes rejected while running)
//   start_i      start / restart a run from the seed
//   abort_i      return to idle (highest priority)
//   lfsr_out_o   current LFSR state
//   busy_o       high while running
//   match_o      pulse when a freshly shifted state equals stop
//   done_o       high in the done state
//   lockup_o     sticky all-ones lockup flag, cleared by start
//   step_cnt_o   saturating count of steps since the last start
module lfsr_gen #(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(16'h1008),
  parameter int unsigned      CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             nreset_i,
  input  logic             cfg_we_i,
  input  logic [1:0]       cfg_addr_i,
  input  logic [WIDTH-1:0] cfg_data_i,
  output logic [WIDTH-1:0] cfg_rdata_o,
  output logic             cfg_ack_o,
  output logic             cfg_err_o,
  input  logic             start_i,
  input  logic             abort_i,
  output logic [WIDTH-1:0] lfsr_out_o,
  output logic             busy_o,
  output logic             match_o,
  output logic             done_o,
  output logic             lockup_o,
  output logic [CNT_W-1:0] step_cnt_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] seed_q, stop_q, taps_q;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lockup_q, lockup_d;
  logic             match_q, match_d;
  logic             reload_q, reload_d;  // wrap: load seed instead of shifting next cycle
  logic             ack_q, err_q;

  logic             fb;
  logic [WIDTH-1:0] shifted;
  logic [CNT_W-1:0] cnt_inc;
  logic             cfg_ok;

  assign fb      = ~^(lfsr_q & taps_q);
  assign shifted = {lfsr_q[WIDTH-2:0], fb};
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign cfg_ok  = cfg_we_i && (state_q != StRun);

  // Configuration registers and write handshake
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      seed_q <= '0;
      stop_q <= '0;
      taps_q <= TAPS;
      mode_q <= '0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      ack_q <= cfg_ok;
      err_q <= cfg_we_i && (state_q == StRun);
      if (cfg_ok) begin
        unique case (cfg_addr_i)
          2'd0:    seed_q <= cfg_data_i;
          2'd1:    stop_q <= cfg_data_i;
          2'd2:    taps_q <= cfg_data_i;
          default: mode_q <= cfg_data_i[1:0];
        endcase
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
    lockup_d = lockup_q;
    match_d  = 1'b0;
    reload_d = reload_q;
    if (abort_i) begin
      state_d  = StIdle;
      reload_d = 1'b0;
      if (state_q == StIdle) lfsr_d = seed_q;
    end else if (start_i) begin
      // seed_q is still the pre-write value if a write lands this cycle
      state_d  = StRun;
      lfsr_d   = seed_q;
      cnt_d    = '0;
      lockup_d = 1'b0;
      reload_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: lfsr_d = seed_q;
        StRun: begin
          if (&lfsr_q) begin
            lockup_d = 1'b1;
            state_d  = StDone;
          end else begin
            cnt_d = cnt_inc;
            if (reload_q) begin
              lfsr_d   = seed_q;
              reload_d = 1'b0;
            end else begin
              lfsr_d = shifted;
              if (shifted == stop_q) begin
                match_d = 1'b1;
                if (mode_q[1])      reload_d = 1'b1;
                else if (mode_q[0]) state_d  = StDone;
              end
            end
          end
        end
        StDone: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q  <= StIdle;
      lfsr_q   <= '0;
      cnt_q    <= '0;
      lockup_q <= 1'b0;
      match_q  <= 1'b0;
      reload_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      cnt_q    <= cnt_d;
      lockup_q <= lockup_d;
      match_q  <= match_d;
      reload_q <= reload_d;
    end
  end

  always_comb begin
    cfg_rdata_o = '0;
    unique case (cfg_addr_i)
      2'd0:    cfg_rdata_o = seed_q;
      2'd1:    cfg_rdata_o = stop_q;
      2'd2:    cfg_rdata_o = taps_q;
      default: cfg_rdata_o = {{(WIDTH-2){1'b0}}, mode_q};
    endcase
  end

  assign cfg_ack_o  = ack_q;
  assign cfg_err_o  = err_q;
  assign lfsr_out_o = lfsr_q;
  assign busy_o     = (state_q == StRun);
  assign done_o     = (state_q == StDone);
  assign match_o    = match_q;
  assign lockup_o   = lockup_q;
  assign step_cnt_o = cnt_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen (WIDTH=16, CNT_W=16): directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_lfsr_gen;

  logic        clk_i = 1'b0;
  logic        nreset_i = 1'b0;
  logic        cfg_we_i = 1'b0;
  logic [1:0]  cfg_addr_i = 2'd0;
  logic [15:0] cfg_data_i = 16'h0;
  logic [15:0] cfg_rdata_o;
  logic        cfg_ack_o, cfg_err_o;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [15:0] lfsr_out_o;
  logic        busy_o, match_o, done_o, lockup_o;
  logic [15:0] step_cnt_o;

  lfsr_gen #(.WIDTH(16), .TAPS(16'h1008), .CNT_W(16)) dut (
    .clk_i      (clk_i),
    .nreset_i   (nreset_i),
    .cfg_we_i   (cfg_we_i),
    .cfg_addr_i (cfg_addr_i),
    .cfg_data_i (cfg_data_i),
    .cfg_rdata_o(cfg_rdata_o),
    .cfg_ack_o  (cfg_ack_o),
    .cfg_err_o  (cfg_err_o),
    .start_i    (start_i),
    .abort_i    (abort_i),
    .lfsr_out_o (lfsr_out_o),
    .busy_o     (busy_o),
    .match_o    (match_o),
    .done_o     (done_o),
    .lockup_o   (lockup_o),
    .step_cnt_o (step_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int PH_IDLE = 0, PH_RUN = 1, PH_DONE = 2;

  logic [15:0] m_seed, m_stop, m_taps, m_lfsr;
  logic [1:0]  m_mode;
  int          m_phase, m_cnt;
  logic        m_lock, m_match, m_reload, m_ack, m_err;

  // Feedback is 1 when an even number of tapped bits are set.
  function automatic logic [15:0] step(input logic [15:0] s, input logic [15:0] t);
    int ones;
    int nxt;
    ones = $countones(s & t);
    nxt  = (int'(s) * 2 + ((ones % 2 == 0) ? 1 : 0)) % 65536;
    return nxt[15:0];
  endfunction

  always @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      m_seed <= 16'h0; m_stop <= 16'h0; m_taps <= 16'h1008; m_mode <= 2'd0;
      m_phase <= PH_IDLE; m_lfsr <= 16'h0; m_cnt <= 0;
      m_lock <= 1'b0; m_match <= 1'b0; m_reload <= 1'b0; m_ack <= 1'b0; m_err <= 1'b0;
    end else begin
      m_ack   <= cfg_we_i && (m_phase != PH_RUN);
      m_err   <= cfg_we_i && (m_phase == PH_RUN);
      m_match <= 1'b0;
      if (cfg_we_i && m_phase != PH_RUN) begin
        if (cfg_addr_i == 2'd0) m_seed <= cfg_data_i;
        if (cfg_addr_i == 2'd1) m_stop <= cfg_data_i;
        if (cfg_addr_i == 2'd2) m_taps <= cfg_data_i;
        if (cfg_addr_i == 2'd3) m_mode <= cfg_data_i[1:0];
      end
      if (abort_i) begin
        m_phase <= PH_IDLE;
        m_reload <= 1'b0;
        if (m_phase == PH_IDLE) m_lfsr <= m_seed;
      end else if (start_i) begin
        m_phase <= PH_RUN; m_lfsr <= m_seed; m_cnt <= 0; m_lock <= 1'b0; m_reload <= 1'b0;
      end else if (m_phase == PH_IDLE) begin
        m_lfsr <= m_seed;
      end else if (m_phase == PH_RUN) begin
        if (m_lfsr == 16'hFFFF) begin
          m_lock <= 1'b1;
          m_phase <= PH_DONE;
        end else begin
          m_cnt <= (m_cnt >= 65535) ? 65535 : m_cnt + 1;
          if (m_reload) begin
            m_lfsr <= m_seed;
            m_reload <= 1'b0;
          end else begin
            m_lfsr <= step(m_lfsr, m_taps);
            if (step(m_lfsr, m_taps) == m_stop) begin
              m_match <= 1'b1;
              if (m_mode[1]) m_reload <= 1'b1;
              else if (m_mode[0]) m_phase <= PH_DONE;
            end
          end
        end
      end
    end
  end

  function automatic logic [15:0] model_rdata(input logic [1:0] a);
    case (a)
      2'd0: return m_seed;
      2'd1: return m_stop;
      2'd2: return m_taps;
      default: return {14'h0, m_mode};
    endcase
  endfunction

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 1'b0;
  always @(negedge clk_i) begin
    if (cmp_en) begin
      check("m_lfsr", 32'(lfsr_out_o), 32'(m_lfsr));
      check("m_cnt", 32'(step_cnt_o), 32'(m_cnt[15:0]));
      check("m_busy", 32'(busy_o), 32'(m_phase == PH_RUN));
      check("m_done", 32'(done_o), 32'(m_phase == PH_DONE));
      check("m_match", 32'(match_o), 32'(m_match));
      check("m_lockup", 32'(lockup_o), 32'(m_lock));
      check("m_ack", 32'(cfg_ack_o), 32'(m_ack));
      check("m_err", 32'(cfg_err_o), 32'(m_err));
      check("m_rdata", 32'(cfg_rdata_o), 32'(model_rdata(cfg_addr_i)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    cfg_we_i = 1'b1; cfg_addr_i = a; cfg_data_i = d;
    cyc();
    cfg_we_i = 1'b0;
  endtask

  initial begin
    cyc(); cyc();
    cmp_en = 1'b1;
    check("rst_lfsr", 32'(lfsr_out_o), 32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);
    cfg_addr_i = 2'd2; #1;
    check("rst_taps", 32'(cfg_rdata_o), 32'h1008);
    cyc();
    nreset_i = 1'b1;
    cyc();

    // stop on match
    wr(2'd0, 16'h0001);
    check("ack_pulse", 32'(cfg_ack_o), 32'h1);
    wr(2'd1, 16'h000F);
    wr(2'd3, 16'h0001);
    start_i = 1'b1; cyc(); start_i = 1'b0;
    check("stop_v0", 32'(lfsr_out_o), 32'h0001);
    cyc(); check("stop_v1", 32'(lfsr_out_o), 32'h0003);
    cyc(); check("stop_v2", 32'(lfsr_out_o), 32'h0007);
    cyc(); check("stop_v3", 32'(lfsr_out_o), 32'h000F);
    check("stop_match", 32'(match_o), 32'h1);
    check("stop_done", 32'(done_o), 32'h1);
    check("stop_cnt", 32'(step_cnt_o), 32'd3);
    cyc(); check("stop_match_gone", 32'(match_o), 32'h0);
    check("stop_hold", 32'(lfsr_out_o), 32'h000F);

    // wrap
    wr(2'd3, 16'h0002);
    start_i = 1'b1; cyc(); start_i = 1'b0;
    cyc(); cyc(); cyc();
    check("wrap_f", 32'(lfsr_out_o), 32'h000F);
    check("wrap_match1", 32'(match_o), 32'h1);
    cyc(); check("wrap_reload", 32'(lfsr_out_o), 32'h0001);
    check("wrap_cnt4", 32'(step_cnt_o), 32'd4);
    cyc(); check("wrap_v3", 32'(lfsr_out_o), 32'h0003);
    check("wrap_cnt5", 32'(step_cnt_o), 32'd5);
    cyc(); cyc();
    check("wrap_match2", 32'(match_o), 32'h1);
    check("wrap_notdone", 32'(done_o), 32'h0);

    // rejected write during run
    wr(2'd1, 16'h1234);
    check("rej_err", 32'(cfg_err_o), 32'h1);
    cfg_addr_i = 2'd1; #1;
    check("rej_stop", 32'(cfg_rdata_o), 32'h000F);
    cyc(); check("rej_err_gone", 32'(cfg_err_o), 32'h0);

    // abort beats start
    abort_i = 1'b1; start_i = 1'b1; cyc(); abort_i = 1'b0; start_i = 1'b0;
    check("abort_busy", 32'(busy_o), 32'h0);

    // lockup
    wr(2'd0, 16'hFFFF);
    start_i = 1'b1; cyc(); start_i = 1'b0;
    cyc();
    check("lock_flag", 32'(lockup_o), 32'h1);
    check("lock_done", 32'(done_o), 32'h1);
    check("lock_val", 32'(lfsr_out_o), 32'hFFFF);
    wr(2'd0, 16'h0001);
    start_i = 1'b1; cyc(); start_i = 1'b0;
    check("lock_clear", 32'(lockup_o), 32'h0);

    // write + start together loads the old seed
    abort_i = 1'b1; cyc(); abort_i = 1'b0;
    start_i = 1'b1; wr(2'd0, 16'h0005); start_i = 1'b0;
    check("wrstart_old", 32'(lfsr_out_o), 32'h0001);
    cyc(); cyc();

    // mid-run reset
    cfg_addr_i = 2'd2;
    nreset_i = 1'b0; #1;
    check("mrst_lfsr", 32'(lfsr_out_o), 32'h0);
    check("mrst_busy", 32'(busy_o), 32'h0);
    check("mrst_cnt", 32'(step_cnt_o), 32'h0);
    check("mrst_taps", 32'(cfg_rdata_o), 32'h1008);
    cyc();
    nreset_i = 1'b1; #1;
    check("mrst_after", 32'(lfsr_out_o), 32'h0);
    cyc();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      cfg_we_i  = ($urandom_range(0, 3) == 0);
      cfg_addr_i = 2'($urandom_range(0, 3));
      case (cfg_addr_i)
        2'd0: case ($urandom_range(0, 3))
                0: cfg_data_i = 16'h0001; 1: cfg_data_i = 16'hFFFF;
                2: cfg_data_i = 16'h0003; default: cfg_data_i = 16'($urandom);
              endcase
        2'd1: case ($urandom_range(0, 3))
                0: cfg_data_i = 16'h000F; 1: cfg_data_i = 16'h0007;
                2: cfg_data_i = 16'h001E; default: cfg_data_i = 16'($urandom);
              endcase
        2'd2: cfg_data_i = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h1008;
        default: cfg_data_i = 16'($urandom);
      endcase
      start_i = ($urandom_range(0, 15) == 0);
      abort_i = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 499) == 0) begin
        nreset_i = 1'b0; #1;
        check("rnd_rst_lfsr", 32'(lfsr_out_o), 32'h0);
        cyc();
        nreset_i = 1'b1;
      end else begin
        cyc();
      end
    end
    cfg_we_i = 1'b0; start_i = 1'b0; abort_i = 1'b0;
    cyc(); cyc();
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 Parameter WIDTH, default 16: LFSR state width, legal range 4..32.
REQ-002 Parameter TAPS, default 16'h1008: feedback tap mask at reset, WIDTH bits, bit i set means state bit i feeds back.
REQ-003 Parameter CNT_W, default 16: step counter width.
REQ-004 clk_i  in  1  clock, all state updates on rising edge.
REQ-005 nreset_i  in  1  reset, asynchronous, active-low.
REQ-006 cfg_we_i  in  1  config write strobe, one cycle per write.
REQ-007 cfg_addr_i  in  2  register select: 0 seed, 1 stop, 2 taps, 3 mode.
REQ-008 cfg_data_i  in  WIDTH  write data.
REQ-009 cfg_rdata_o  out  WIDTH  combinational readback of the register selected by cfg_addr_i; mode is zero-extended.
REQ-010 cfg_ack_o  out  1  one-cycle pulse, one cycle after an accepted write.
REQ-011 cfg_err_o  out  1  one-cycle pulse, one cycle after a rejected write.
REQ-012 start_i  in  1  start or restart a sequence run.
REQ-013 abort_i  in  1  return to IDLE.
REQ-014 lfsr_out_o  out  WIDTH  current LFSR state, registered.
REQ-015 busy_o  out  1  high in RUN.
REQ-016 match_o  out  1  one-cycle pulse when a newly shifted state equals stop.
REQ-017 done_o  out  1  high in DONE.
REQ-018 lockup_o  out  1  sticky lockup flag, cleared by start.
REQ-019 step_cnt_o  out  CNT_W  shifts since the last start.

Function
REQ-020 Registers: seed, stop and taps are WIDTH bits; mode is 2 bits. Mode bit0 stop_en: stop on match. Mode bit1 wrap: on match reload seed and continue.
REQ-021 Write acceptance: writes are accepted in IDLE and DONE and rejected in RUN. A rejected write leaves registers unchanged and pulses cfg_err_o.
REQ-022 Feedback bit: fb = XNOR reduction of (state AND taps).
REQ-023 Next state: {state[WIDTH-2:0], fb}.
REQ-024 FSM states are IDLE, RUN and DONE.
REQ-025 IDLE: lfsr_out_o follows the seed register each cycle, with 1-cycle latency after a seed write. step_cnt_o holds its value.
REQ-026 start_i in IDLE or DONE:
- next state RUN;
- lfsr_out_o <= seed;
- step_cnt_o <= 0;
- lockup_o <= 0.
REQ-027 RUN shifting: each cycle lfsr_out_o <= next state. step_cnt_o increments and saturates at all-ones.
REQ-028 Match detection compares the newly shifted value only. The loaded seed never produces a match, so seed == stop runs one full period before matching.
REQ-029 Match with stop_en=1, wrap=0:
- match_o pulses;
- FSM moves to DONE;
- lfsr_out_o holds the matching value.
REQ-030 Match with wrap=1:
- match_o pulses;
- lfsr_out_o <= seed on the following cycle instead of a shift;
- step_cnt_o keeps counting;
- FSM stays in RUN.
- wrap overrides stop_en.
REQ-031 Match with mode=0: match_o pulses and the FSM stays in RUN (free-run).
REQ-032 Lockup: state all-ones in RUN sets lockup_o and moves the FSM to DONE on the next cycle, regardless of mode.
REQ-033 A seed of all-ones with start causes lockup on the first RUN cycle.
REQ-034 abort_i in any state moves the FSM to IDLE next cycle. abort_i has priority over start_i and over a match.
REQ-035 start_i while in RUN restarts: reload seed and clear the counter.
REQ-036 Simultaneous cfg write and start_i in IDLE or DONE: the write is accepted, and start loads the pre-write seed.
REQ-037 DONE: lfsr_out_o and step_cnt_o hold their values; done_o = 1.

Reset
REQ-038 On nreset_i low, asynchronously:
- seed = 0, stop = 0, taps = TAPS, mode = 0;
- FSM = IDLE;
- lfsr_out_o = 0, step_cnt_o = 0;
- all 1-bit outputs = 0.
REQ-039 Reset asserted mid-RUN aborts immediately with no pulse on match_o or done_o. After deassertion the block is in IDLE with lfsr_out_o = 0 until the next clock loads the seed.

Verification
REQ-040 Stop on match: WIDTH=16, taps=0x1008, seed=0x0001, stop=0x000F, mode=1, start.
- Required: lfsr_out_o = 0x0001, 0x0003, 0x0007, 0x000F.
- Then match_o pulses once, done_o = 1 and step_cnt_o = 3.
REQ-041 Wrap: same setup with mode=2.
- Required: after 0x000F the next value is 0x0001, then 0x0003.
- match_o pulses every 4 cycles; done_o stays 0; step_cnt_o counts 4, 5, ...
REQ-042 Lockup: seed=0xFFFF, start.
- Required: lockup_o = 1, done_o = 1 and lfsr_out_o = 0xFFFF.
- A subsequent start with seed=0x0001 clears lockup_o.
REQ-043 Rejected write: a write to stop during RUN gives cfg_err_o = 1 for one cycle; cfg_rdata_o at address 1 is unchanged.
REQ-044 Abort priority: abort_i and start_i asserted together in RUN give IDLE next cycle, with busy_o = 0.
REQ-045 Mid-run reset: nreset_i pulsed low in RUN gives all outputs 0 immediately and taps readback = 0x1008.
